// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The encoder uses the slave modport; a stimulus source uses master.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs decoded fields into words tagged with sequential
// addresses and queues them in a small FIFO. ENC_CHECK_EN adds a per-entry field-check error bit.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  input logic           clr,
  instr_encoder_if.slave enc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      addr_cnt;
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      addr_mem  [DEPTH];
  logic [31:0]      enc_word;
  logic             push;
  logic             pop;

  always_comb begin
    enc_word = 32'h0000_0013;
    case (enc.in_fmt)
      3'd0: enc_word = {enc.in_funct7, enc.in_rs2, enc.in_rs1, enc.in_funct3,
                        enc.in_rd, enc.in_opcode};
      3'd1: enc_word = {enc.in_imm[11:0], enc.in_rs1, enc.in_funct3,
                        enc.in_rd, enc.in_opcode};
      3'd2: enc_word = {enc.in_imm[11:5], enc.in_rs2, enc.in_rs1, enc.in_funct3,
                        enc.in_imm[4:0], enc.in_opcode};
      3'd3: enc_word = {enc.in_imm[12], enc.in_imm[10:5], enc.in_rs2, enc.in_rs1,
                        enc.in_funct3, enc.in_imm[4:1], enc.in_imm[11], enc.in_opcode};
      3'd4: enc_word = {enc.in_imm[31:12], enc.in_rd, enc.in_opcode};
      3'd5: enc_word = {enc.in_imm[20], enc.in_imm[10:1], enc.in_imm[11],
                        enc.in_imm[19:12], enc.in_rd, enc.in_opcode};
      default: enc_word = 32'h0000_0013;
    endcase
  end

  // Ready depends only on occupancy, so a same-cycle pop never frees a slot for a push.
  assign enc.in_ready  = (count != CNT_W'(DEPTH));
  assign enc.out_valid = (count != '0);
  assign push = enc.in_valid && enc.in_ready && !clr;
  assign pop  = enc.out_valid && enc.out_ready && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= BASE_ADDR;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        addr_cnt <= addr_cnt + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= enc_word;
      addr_mem[wr_ptr]  <= addr_cnt;
    end
  end

  // Storage is never reset; outputs are masked while the FIFO is empty.
  assign enc.out_instr = enc.out_valid ? instr_mem[rd_ptr] : 32'h0;
  assign enc.out_addr  = enc.out_valid ? addr_mem[rd_ptr]  : 32'h0;

`ifdef ENC_CHECK_EN
  logic err_mem [DEPTH];
  logic enc_err;

  always_comb begin
    enc_err = 1'b0;
    if (enc.in_fmt > 3'd5)              enc_err = 1'b1;
    if (enc.in_opcode[1:0] != 2'b11)    enc_err = 1'b1;
    if ((enc.in_fmt == 3'd3 || enc.in_fmt == 3'd5) && enc.in_imm[0]) enc_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) err_mem[wr_ptr] <= enc_err;
  end

  assign enc.out_err = enc.out_valid ? err_mem[rd_ptr] : 1'b0;
`else
  assign enc.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan cases plus random
// traffic compared against a queue-based reference model.
module tb_instr_encoder;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic clk;
  logic rst_n;
  logic clr;
  instr_encoder_if enc_if ();

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .enc   (enc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_instr [$];
  logic [31:0] q_addr  [$];
  logic [31:0] q_err   [$];
  logic [31:0] model_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference encoding built with shifts and masks from the field layout tables.
  function automatic logic [31:0] ref_enc(input int fmt, input logic [31:0] op,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    case (fmt)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      2: w = (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | ((imm & 32'h1f) << 7) | op;
      3: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hf) << 8)
             | (((imm >> 11) & 1) << 7) | op;
      4: w = (imm & 32'hffff_f000) | (rd << 7) | op;
      5: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
             | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12) | (rd << 7) | op;
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] ref_err(input int fmt, input logic [31:0] op,
                                          input logic [31:0] imm);
`ifdef ENC_CHECK_EN
    return ((fmt > 5) || ((op & 3) != 3) || ((fmt == 3 || fmt == 5) && (imm & 1) != 0))
           ? 32'd1 : 32'd0;
`else
    return (fmt < 0 && op == imm) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic set_fields(input int fmt, input int op, input int f3, input int f7,
                            input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    enc_if.in_fmt    = 3'(fmt);
    enc_if.in_opcode = 7'(op);
    enc_if.in_funct3 = 3'(f3);
    enc_if.in_funct7 = 7'(f7);
    enc_if.in_rd     = 5'(rd);
    enc_if.in_rs1    = 5'(rs1);
    enc_if.in_rs2    = 5'(rs2);
    enc_if.in_imm    = imm;
  endtask

  task automatic model_reset();
    q_instr.delete();
    q_addr.delete();
    q_err.delete();
    model_addr = BASE_ADDR;
  endtask

  task automatic check_outputs();
    chk("in_ready", {31'b0, enc_if.in_ready}, (q_instr.size() != DEPTH) ? 32'd1 : 32'd0);
    chk("out_valid", {31'b0, enc_if.out_valid}, (q_instr.size() != 0) ? 32'd1 : 32'd0);
    if (q_instr.size() != 0) begin
      chk("out_instr", enc_if.out_instr, q_instr[0]);
      chk("out_addr", enc_if.out_addr, q_addr[0]);
      chk("out_err", {31'b0, enc_if.out_err}, q_err[0]);
    end else begin
      chk("out_instr_idle", enc_if.out_instr, 32'h0);
      chk("out_addr_idle", enc_if.out_addr, 32'h0);
      chk("out_err_idle", {31'b0, enc_if.out_err}, 32'h0);
    end
  endtask

  // One clock: check outputs against the model, predict, advance, update the model.
  task automatic cycle(input logic v, input logic r, input logic c);
    bit          do_push;
    bit          do_pop;
    logic [31:0] w;
    logic [31:0] e;
    enc_if.in_valid  = v;
    enc_if.out_ready = r;
    clr              = c;
    check_outputs();
    do_push = v && !c && (q_instr.size() < DEPTH);
    do_pop  = r && !c && (q_instr.size() > 0);
    w = ref_enc(int'(enc_if.in_fmt), 32'(enc_if.in_opcode), 32'(enc_if.in_funct3),
                32'(enc_if.in_funct7), 32'(enc_if.in_rd), 32'(enc_if.in_rs1),
                32'(enc_if.in_rs2), enc_if.in_imm);
    e = ref_err(int'(enc_if.in_fmt), 32'(enc_if.in_opcode), enc_if.in_imm);
    @(posedge clk);
    #1;
    if (c) begin
      model_reset();
    end else begin
      if (do_pop) begin
        void'(q_instr.pop_front());
        void'(q_addr.pop_front());
        void'(q_err.pop_front());
      end
      if (do_push) begin
        q_instr.push_back(w);
        q_addr.push_back(model_addr);
        q_err.push_back(e);
        model_addr = model_addr + 32'd4;
      end
    end
    enc_if.in_valid = 1'b0;
    clr             = 1'b0;
  endtask

  task automatic rand_fields();
    set_fields($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 7),
               $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    enc_if.in_valid  = 1'b0;
    enc_if.out_ready = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Sequential requests with the consumer always ready.
    set_fields(1, 8'h13, 0, 0, 1, 0, 0, 32'd5);
    cycle(1, 1, 0);
    chk("tp_i_word", enc_if.out_instr, 32'h0050_0093);
    chk("tp_i_addr", enc_if.out_addr, 32'h0);
    set_fields(0, 8'h33, 0, 0, 3, 1, 2, 32'h0);
    cycle(1, 1, 0);
    chk("tp_r_word", enc_if.out_instr, 32'h0020_81B3);
    chk("tp_r_addr", enc_if.out_addr, 32'h4);
    set_fields(3, 8'h63, 0, 0, 0, 1, 2, 32'd8);
    cycle(1, 1, 0);
    chk("tp_b_word", enc_if.out_instr, 32'h0020_8463);
    chk("tp_b_addr", enc_if.out_addr, 32'h8);
    set_fields(5, 8'h6F, 0, 0, 1, 0, 0, 32'd16);
    cycle(1, 1, 0);
    chk("tp_j_word", enc_if.out_instr, 32'h0100_00EF);
    chk("tp_j_addr", enc_if.out_addr, 32'hC);
    set_fields(4, 8'h37, 0, 0, 5, 0, 0, 32'h1234_5000);
    cycle(1, 1, 0);
    chk("tp_u_word", enc_if.out_instr, 32'h1234_52B7);
    cycle(0, 1, 0);

    // Fill to full with the consumer stalled, then pop while pushing.
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      cycle(1, 0, 0);
    end
    chk("full_ready", {31'b0, enc_if.in_ready}, 32'd0);
    rand_fields();
    cycle(1, 1, 0);
    chk("pop_no_push_ready", {31'b0, enc_if.in_ready}, 32'd1);
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);

    // Synchronous clear with a concurrent push.
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      cycle(1, 0, 0);
    end
    rand_fields();
    cycle(1, 0, 1);
    chk("clr_valid", {31'b0, enc_if.out_valid}, 32'd0);
    rand_fields();
    cycle(1, 0, 0);
    chk("clr_base_addr", enc_if.out_addr, BASE_ADDR);
    cycle(0, 1, 0);

    // Asynchronous reset with two entries queued.
    for (int i = 0; i < 2; i++) begin
      rand_fields();
      cycle(1, 0, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, enc_if.out_valid}, 32'd0);
    chk("async_rst_ready", {31'b0, enc_if.in_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_fields();
    cycle(1, 0, 0);
    chk("rst_base_addr", enc_if.out_addr, BASE_ADDR);
    cycle(0, 1, 0);

`ifdef ENC_CHECK_EN
    set_fields(6, 8'h13, 0, 0, 1, 0, 0, 32'd0);
    cycle(1, 1, 0);
    chk("chk_rsv_word", enc_if.out_instr, 32'h0000_0013);
    chk("chk_rsv_err", {31'b0, enc_if.out_err}, 32'd1);
    set_fields(3, 8'h63, 0, 0, 0, 1, 2, 32'd3);
    cycle(1, 1, 0);
    chk("chk_b_odd_err", {31'b0, enc_if.out_err}, 32'd1);
    set_fields(1, 8'h13, 0, 0, 1, 0, 0, 32'd5);
    cycle(1, 1, 0);
    chk("chk_i_ok_err", {31'b0, enc_if.out_err}, 32'd0);
    cycle(0, 1, 0);
`endif

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, 0);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields (format, opcode, funct3/funct7, register indices, immediate) over a valid/ready handshake and emits packed 32-bit instruction words tagged with sequential addresses. It is the inverse of `ControlUnit`. It feeds instruction memory preload and generates self-checking stimulus for the decode path, buffering results in a small FIFO.

## Interface
- `DEPTH`, 4, output FIFO entries; power of two, ≥2.
- `BASE_ADDR`, 32'h0000_0000, address tagged on the first word after reset or `clr`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `clr` in 1: synchronous flush.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when high with `in_valid`.
- `in_fmt` in 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 reserved.
- `in_opcode` in 7; `in_funct3` in 3; `in_funct7` in 7.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each.
- `in_imm` in 32: byte-offset or raw immediate as the ISA defines it.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer takes head entry.
- `out_instr` out 32: encoded word.
- `out_addr` out 32: address of that word.
- `out_err` out 1: field-check error (only with `ENC_CHECK_EN`; tied 0 otherwise).

## Operation
- Encoding is combinational on the inputs and is written into the FIFO on acceptance (`in_valid && in_ready`).
  - R: `{funct7, rs2, rs1, funct3, rd, opcode}`
  - I: `{imm[11:0], rs1, funct3, rd, opcode}`
  - S: `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`
  - B: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`
  - U: `{imm[31:12], rd, opcode}`
  - J: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}`
  - Reserved fmt: encodes 32'h0000_0013 (NOP).
  - Unused fields are ignored. Immediate bits outside the format's range are discarded.
- Address counter: the stored address equals the counter value at acceptance. The counter increments by 4 per accepted request and wraps modulo 2^32 with no flag.
- FIFO: read/write pointers of log2(DEPTH) bits plus an occupancy count of 0..DEPTH. Pointers wrap naturally.
  - `in_ready = (count != DEPTH)`. It depends only on count, so there is no push on a full FIFO even when a pop happens in the same cycle.
  - `out_valid = (count != 0)`. `out_instr`, `out_addr` and `out_err` come from the head entry and are held stable while `out_valid && !out_ready`.
  - Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- `clr`: on the next edge, count, pointers and the address counter return to their reset values. A push or pop presented in the same cycle is discarded. `clr` has priority over all other activity.
- Reset (`rst_n` low, asynchronous):
  - count = 0, pointers = 0, address counter = `BASE_ADDR`.
  - Outputs: `out_valid`=0, `in_ready`=1, `out_instr`=0, `out_addr`=0, `out_err`=0.
  - Storage contents are don't-care, but outputs are forced to 0 while count = 0.

## Timing
- Latency: a request accepted at edge N appears with `out_valid`=1 after edge N, if the FIFO was empty.
- Throughput: 1 word/cycle sustained when `out_ready` is held high.
- No combinational path from `out_ready` to `in_ready`. No combinational path from the inputs to the outputs.
- Reset deassertion is assumed synchronized upstream. The first acceptance can occur on the first edge after `rst_n` rises.

## Configuration
- `ENC_CHECK_EN` defined: each entry stores an error bit, presented on `out_err`. The bit is set when any of these holds:
  - fmt is reserved;
  - `in_opcode[1:0] != 2'b11`;
  - fmt is B or J and `in_imm[0]` = 1.

  The word is still encoded and enqueued.
- `ENC_CHECK_EN` undefined: no error storage, and `out_err` is constant 0.

## Test plan
- Reset, then four sequential requests with `out_ready`=1:
  - I: op 0x13, rd 1, rs1 0, imm 5 → 0x00500093 @0x0
  - R: op 0x33, rd 3, rs1 1, rs2 2 → 0x002081B3 @0x4
  - B: op 0x63, rs1 1, rs2 2, imm 8 → 0x00208463 @0x8
  - J: op 0x6F, rd 1, imm 16 → 0x010000EF @0xC
- U: op 0x37, rd 5, imm 0x12345000 → 0x123452B7, one cycle after acceptance.
- `out_ready`=0, push 5 requests → first 4 accepted, `in_ready`=0 after the 4th. Pop once while pushing → no push that cycle, push succeeds the next cycle, and order and addresses are preserved.
- Fill 3 entries, assert `clr` with concurrent `in_valid` → `out_valid`=0 next cycle. The next accepted word has address `BASE_ADDR`.
- `rst_n` asserted mid-stream with 2 entries queued → `out_valid`=0 immediately (asynchronous), address restarts at `BASE_ADDR`.
- With `ENC_CHECK_EN`: fmt 6 → 0x00000013, `out_err`=1. B with imm 3 → `out_err`=1. Valid I → `out_err`=0.
